// File: rtl/pwm_ctrl_pkg.sv
// Shared constants, command field layout, filter FSM states and the duty slew helper
// for the PWM ramp controller.
package pwm_ctrl_pkg;

  localparam int NUM_CH  = 4;
  localparam int DUTY_W  = 6;
  localparam int CNT_MAX = 62;

  localparam int CH_MSB   = 7;
  localparam int CH_LSB   = 6;
  localparam int DUTY_MSB = 5;
  localparam int DUTY_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACCEPT = 2'd2
  } cmd_state_t;

  // The difference is taken before the min, so the result never passes the target.
  function automatic logic [DUTY_W-1:0] ramp_next(input logic [DUTY_W-1:0] duty,
                                                  input logic [DUTY_W-1:0] target,
                                                  input logic [DUTY_W-1:0] step);
    logic [DUTY_W-1:0] diff;
    diff      = '0;
    ramp_next = duty;
    if (duty < target) begin
      diff      = target - duty;
      ramp_next = duty + ((diff < step) ? diff : step);
    end else if (duty > target) begin
      diff      = duty - target;
      ramp_next = duty - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: target register, duty slew at period wrap, registered compare output.
// PWM_SOFT_RAMP_EN selects slew-limited ramping; otherwise duty jumps to target at wrap.
module pwm_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int RAMP_STEP = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              i_wr_en,
  input  logic [DUTY_W-1:0] i_wr_duty,
  input  logic              i_wrap,
  input  logic [DUTY_W-1:0] i_cnt,
  output logic              o_pwm,
  output logic              o_at_target
);

`ifdef PWM_SOFT_RAMP_EN
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);
`else
  // A full-scale step lands on the target in a single update.
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP) | {DUTY_W{1'b1}};
`endif

  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] r_duty;
  logic              r_pwm;

  // Ramp reads the pre-write target when a command lands on the wrap cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_target <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wrap) r_duty <= ramp_next(r_duty, r_target, STEP);
      if (i_wr_en) r_target <= i_wr_duty;
      r_pwm <= (i_cnt < r_duty);
    end
  end

  assign o_pwm       = r_pwm;
  assign o_at_target = (r_duty == r_target);

endmodule

// File: rtl/pwm_ramp_controller.sv
// HPS PIO command decoder with glitch filter, PWM tick/period timebase and four ramped
// PWM channels. Optional slew limiting is enabled by defining PWM_SOFT_RAMP_EN.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int RAMP_STEP = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        cmd_in,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cmd_ack,
  output logic [NUM_CH-1:0] at_target,
  output logic              busy
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [DUTY_W-1:0] r_cnt;
  logic              w_tick;
  logic              w_wrap;

  cmd_state_t        r_state;
  logic [7:0]        r_cand;
  logic [7:0]        r_last_cmd;
  logic              r_cmd_ack;
  logic              w_accept;

  logic [NUM_CH-1:0] w_wr_en;
  logic [NUM_CH-1:0] w_pwm;
  logic [NUM_CH-1:0] w_at_target;

  assign w_tick = (r_pre == PRE_LAST);
  assign w_wrap = w_tick && (r_cnt == DUTY_W'(CNT_MAX));

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_cnt <= (r_cnt == DUTY_W'(CNT_MAX)) ? '0 : r_cnt + 1'b1;
    end
  end

  // A byte must be seen on two consecutive samples and differ from the last accepted one.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_last_cmd <= '0;
      r_cmd_ack  <= 1'b0;
    end else begin
      r_cmd_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_in != r_last_cmd) begin
            r_cand  <= cmd_in;
            r_state <= ARM;
          end
        end
        ARM: begin
          if (cmd_in == r_cand) begin
            r_state   <= ACCEPT;
            r_cmd_ack <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCEPT: begin
          r_last_cmd <= r_cand;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_accept = (r_state == ACCEPT);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_en[g] = w_accept && (r_cand[CH_MSB:CH_LSB] == 2'(g));

    pwm_channel #(
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .i_wr_en      (w_wr_en[g]),
      .i_wr_duty    (r_cand[DUTY_MSB:DUTY_LSB]),
      .i_wrap       (w_wrap),
      .i_cnt        (r_cnt),
      .o_pwm        (w_pwm[g]),
      .o_at_target  (w_at_target[g])
    );
  end

  assign pwm_out   = w_pwm;
  assign cmd_ack   = r_cmd_ack;
  assign at_target = w_at_target;
  assign busy      = |(~w_at_target);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: per-cycle reference model, directed vector table,
// coincident-event and reset-mid-ramp sequences, then randomized command traffic.
module tb_pwm_ramp_controller;

  localparam int PRESCALE  = 4;
  localparam int RAMP_STEP = 8;
  localparam int PERIOD    = 63 * PRESCALE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [3:0] pwm_out;
  logic       cmd_ack;
  logic [3:0] at_target;
  logic       busy;

  always #5 clk = ~clk;

  pwm_ramp_controller #(
    .PRESCALE (PRESCALE),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .cmd_in       (cmd),
    .pwm_out      (pwm_out),
    .cmd_ack      (cmd_ack),
    .at_target    (at_target),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time is a plain cycle count since reset; the filter is tracked
  // as a phase number (0 waiting for change, 1 confirming, 2 accepting).
  int         m_cyc;
  int         m_phase;
  logic [7:0] m_cand;
  logic [7:0] m_last;
  int         m_duty[4];
  int         m_tgt[4];
  logic [3:0] m_pwm;

  typedef struct {
    logic [7:0] cmd;
    int         hold;
    int         exp_acks;
    int         exp_hi0;
    int         exp_hi1;
    int         exp_busy;
  } vec_t;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d t=%0t", name, act, exp, m_cyc, $time);
    end
  endtask

  task automatic model_edge(input logic [7:0] c, input logic r);
    int cnt;
    bit tick, wrap;
    if (!r) begin
      m_cyc = 0; m_phase = 0; m_cand = 8'h00; m_last = 8'h00; m_pwm = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_duty[i] = 0;
        m_tgt[i]  = 0;
      end
      return;
    end
    cnt  = (m_cyc / PRESCALE) % 63;
    tick = ((m_cyc % PRESCALE) == PRESCALE - 1);
    wrap = tick && (cnt == 62);
    for (int i = 0; i < 4; i++) m_pwm[i] = (cnt < m_duty[i]);
    if (wrap) begin
      for (int i = 0; i < 4; i++) begin
`ifdef PWM_SOFT_RAMP_EN
        if (m_duty[i] < m_tgt[i]) m_duty[i] += imin(RAMP_STEP, m_tgt[i] - m_duty[i]);
        else if (m_duty[i] > m_tgt[i]) m_duty[i] -= imin(RAMP_STEP, m_duty[i] - m_tgt[i]);
`else
        m_duty[i] = m_tgt[i];
`endif
      end
    end
    case (m_phase)
      0: if (c != m_last) begin m_cand = c; m_phase = 1; end
      1: m_phase = (c == m_cand) ? 2 : 0;
      default: begin
        m_tgt[m_cand[7:6]] = int'(m_cand[5:0]);
        m_last  = m_cand;
        m_phase = 0;
      end
    endcase
    m_cyc++;
  endtask

  task automatic step(input logic [7:0] c, input logic r);
    logic [3:0] exp_at;
    cmd   = c;
    rst_n = r;
    @(posedge clk);
    model_edge(c, r);
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_at[i] = (m_duty[i] == m_tgt[i]);
    check("pwm_out", int'(pwm_out), int'(m_pwm));
    check("cmd_ack", int'(cmd_ack), (m_phase == 2) ? 1 : 0);
    check("at_target", int'(at_target), int'(exp_at));
    check("busy", int'(busy), (exp_at != 4'hF) ? 1 : 0);
  endtask

  vec_t vecs[9];

  initial begin
    int acks, hi0, hi1, hi2, hold, sel;
    logic [7:0] rc;

    vecs[0] = '{8'h50, 1, 0, -1, -1, 0};
    vecs[1] = '{8'h00, 4, 0, -1, -1, 0};
    vecs[2] = '{8'h10, 800, 1, 64, 0, 0};
    vecs[3] = '{8'h04, 800, 1, 16, 0, 0};
`ifdef PWM_SOFT_RAMP_EN
    vecs[4] = '{8'h7F, 300, 1, -1, -1, 1};
`else
    vecs[4] = '{8'h7F, 300, 1, -1, -1, 0};
`endif
    vecs[5] = '{8'h7F, 2200, 0, 16, 252, 0};
    vecs[6] = '{8'h41, 1, 0, -1, -1, -1};
    vecs[7] = '{8'h7F, 5, 0, -1, -1, -1};
    vecs[8] = '{8'h00, 5, 1, -1, -1, -1};

    // Reset and quiet idle.
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ack", int'(cmd_ack), 0);
    check("rst_at_target", int'(at_target), 4'hF);
    check("rst_busy", int'(busy), 0);
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      step(8'h00, 1'b1);
      acks += int'(cmd_ack);
    end
    check("idle_acks", acks, 0);

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      acks = 0; hi0 = 0; hi1 = 0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        step(vecs[v].cmd, 1'b1);
        acks += int'(cmd_ack);
        if (c >= vecs[v].hold - PERIOD) begin
          hi0 += int'(pwm_out[0]);
          hi1 += int'(pwm_out[1]);
        end
      end
      check($sformatf("vec%0d_acks", v), acks, vecs[v].exp_acks);
      if (vecs[v].exp_hi0 >= 0) check($sformatf("vec%0d_hi0", v), hi0, vecs[v].exp_hi0);
      if (vecs[v].exp_hi1 >= 0) check($sformatf("vec%0d_hi1", v), hi1, vecs[v].exp_hi1);
      if (vecs[v].exp_busy >= 0) check($sformatf("vec%0d_busy", v), int'(busy), vecs[v].exp_busy);
    end

    // Command accepted on the wrap cycle: duty holds for one more period.
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0);
    for (int i = 0; i < PERIOD && (m_cyc % PERIOD) != PERIOD - 3; i++) step(8'h00, 1'b1);
    step(8'h94, 1'b1);
    step(8'h94, 1'b1);
    check("coinc_ack", int'(cmd_ack), 1);
    hi2 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(8'h94, 1'b1);
      hi2 += int'(pwm_out[2]);
    end
    check("coinc_hi_first", hi2, 0);
    hi2 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(8'h94, 1'b1);
      hi2 += int'(pwm_out[2]);
    end
`ifdef PWM_SOFT_RAMP_EN
    check("coinc_hi_second", hi2, 32);
`else
    check("coinc_hi_second", hi2, 80);
`endif

    // Reset in the middle of a ramp with the command held.
    for (int i = 0; i < 2; i++) step(8'h00, 1'b0);
    for (int i = 0; i < 600; i++) step(8'h7F, 1'b1);
    step(8'h7F, 1'b0);
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_at_target", int'(at_target), 4'hF);
    check("midrst_ack", int'(cmd_ack), 0);
    step(8'h7F, 1'b1);
    check("rel_ack_1", int'(cmd_ack), 0);
    step(8'h7F, 1'b1);
    check("rel_ack_2", int'(cmd_ack), 1);

    // Randomized traffic: glitches, short holds, long holds, occasional reset.
    for (int s = 0; s < 60; s++) begin
      rc  = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel < 2) hold = 1;
      else if (sel < 3) hold = 2;
      else hold = $urandom_range(3, 400);
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < $urandom_range(1, 2); i++) step(rc, 1'b0);
      end
      for (int i = 0; i < hold; i++) step(rc, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Fabric-side controller for the HPS-driven 8-bit PWM command PIO (`pwm_input_0_export`). It decodes each new command byte into a channel select and a target duty, and filters PIO glitches with a stability check. It slews each of four channel duties toward its target, applying updates only at PWM period boundaries, and drives four glitch-free PWM outputs. It sits between the HPS system instance and the board's PWM pins.

## Interface
Parameters:
- `PRESCALE`, default 4: clock cycles per PWM tick; must be ≥1.
- `RAMP_STEP`, default 8: maximum duty change per channel per PWM period; must be 1..63.

Ports:
- `clk_clk`  in  1: sole clock.
- `reset_reset_n`  in  1: reset, synchronous and active-low.
- `cmd_in`  in  8: PIO command byte; [7:6] = channel 0..3, [5:0] = target duty 0..63.
- `pwm_out`  out  4: PWM output per channel.
- `cmd_ack`  out  1: 1-cycle pulse when a command is accepted.
- `at_target`  out  4: channel duty equals channel target.
- `busy`  out  1: OR of `~at_target`.

## Operation
- Command filter FSM:
  - States: IDLE, ARM, ACCEPT.
  - IDLE: if `cmd_in` ≠ `last_cmd`, capture `cand` = `cmd_in` and go to ARM.
  - ARM: if `cmd_in` == `cand`, go to ACCEPT; otherwise return to IDLE.
  - ACCEPT: write `target[cand[7:6]]` = `cand[5:0]`, set `last_cmd` = `cand`, pulse `cmd_ack`, then go to IDLE.
  - `last_cmd` resets to 0x00.
  - Re-sending a byte identical to `last_cmd` is not detected. Software must alter the byte, for example by writing to another channel in between.
- Tick generator: prescaler runs 0..PRESCALE-1. `tick` asserts in the cycle the prescaler equals PRESCALE-1.
- Period counter `cnt` runs 0..62 and advances on `tick`. `wrap` = `tick` && `cnt` == 62, so one period is 63 ticks.
- Output: `pwm_out[i]` is registered as (`cnt` < `duty[i]`).
  - Duty 0 gives constant low.
  - Duty 63 gives constant high.
- Duty update, per channel, evaluated only on `wrap`:
  - If `duty` < `target`: `duty` += min(RAMP_STEP, `target`-`duty`).
  - If `duty` > `target`: `duty` -= min(RAMP_STEP, `duty`-`target`).
  - Arithmetic is unsigned 6-bit. Compute the difference before the min so the result never overshoots or wraps.
- `at_target[i]` = (`duty[i]` == `target[i]`), combinational from registers.

## Timing
- Reset values:
  - `pwm_out`, `cmd_ack`, `busy` = 0; `at_target` = 4'hF.
  - All `duty` and `target` registers, `cnt`, prescaler = 0.
  - FSM state IDLE; `cand` and `last_cmd` = 0x00.
- Command latency:
  - `cmd_in` change sampled at edge N moves the FSM to ARM.
  - Stable at N+1 moves it to ACCEPT.
  - At N+2, `target` is updated and `cmd_ack` is high for that one cycle.
- Glitch rejection: a value present for exactly one sample is never accepted.
- Target-to-output: the new `target` takes effect at the first `wrap` after it is written. `pwm_out` reflects the new `duty` one cycle later (registered compare).
- Simultaneous ACCEPT and `wrap`: the ramp uses the pre-write `target`. The new target is applied at the following `wrap`.
- Reset mid-ramp: all state is cleared at the next `clk_clk` edge with `reset_reset_n` low.
- A nonzero `cmd_in` held through reset is accepted 2 cycles after release.

## Configuration
- Macro: `PWM_SOFT_RAMP_EN`.
  - Defined: slew-limited ramp as above.
  - Undefined: at `wrap`, `duty` = `target` directly, and the `RAMP_STEP` parameter is ignored.

## Structure
- Package `pwm_ctrl_pkg` holds:
  - `NUM_CH`=4, `DUTY_W`=6, `CNT_MAX`=62.
  - Command field positions `CH_MSB`/`CH_LSB`/`DUTY_MSB`/`DUTY_LSB`.
  - Filter FSM state enum `cmd_state_t`.
- Sub-module `pwm_channel`, instantiated 4×, holds the target register, duty ramp and output compare. The top level keeps the filter FSM, prescaler and period counter.

## Test plan
Bench parameters: `PRESCALE`=4, `RAMP_STEP`=8; a period is 252 cycles.
- **Reset:** reset with `cmd_in`=0x00 → all outputs at reset values, no `cmd_ack` for 1000 cycles.
- **Ramp:** `cmd_in`=0x7F (ch1, duty 63), `PWM_SOFT_RAMP_EN` defined → `cmd_ack` 2 cycles after change; `duty[1]` = 8, 16, …, 56, 63 over 8 wraps; then `pwm_out[1]` constant high and `busy` falls. Without the macro → constant high after the first wrap.
- **Glitch:** `cmd_in` 0x00→0x50 for one cycle, then back → no `cmd_ack`, `target[1]` stays 0.
- **Duty/ramp-down:** `cmd_in`=0x10 (ch0, duty 16) → after 2 wraps `pwm_out[0]` high 64 of 252 cycles. Then `cmd_in`=0x04 → duty 8, then 4; `at_target[0]` = 1.
- **Coincident events:** `cmd_ack` on the same cycle as `wrap` → that channel's duty is unchanged at this wrap and moves at the next one.
- **Reset mid-ramp:** assert reset during the 0x7F ramp → next cycle `pwm_out`=0, `duty[1]`=0; with `cmd_in` still 0x7F, `cmd_ack` fires 2 cycles after release.
